// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: sequencer for a weight-stationary systolic MAC array.
//   Loads an nPEy x nPEx weight bank row by row, then streams a programmed
//   number of im2col activation vectors into the array (one per cycle, with
//   back-pressure). A valid shift register tracks the array latency so that
//   array outputs are captured into res_data with a one-cycle res_valid strobe.
//   done pulses for one cycle after the last result.
//
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   start, num_vectors job start (IDLE only) and vector count, latched on start
//   w_valid/w_ready    weight row handshake, w_data = one row (nPEx elements)
//   act_valid/ready    activation handshake, act_data = one im2col vector
//   array_act          registered activation vector to the array
//   array_weight       weight bank, element (r,c) at (r*nPEx+c)*dataSize
//   array_result       array outputs, nPEx elements of outputSize
//   res_valid/res_data registered result strobe and data
//   busy, done         not-IDLE flag, end-of-job pulse
module tpu_seq_ctrl #(
  parameter int dataSize      = 8,
  parameter int kernelWidth   = 3,
  parameter int numOutChannel = 3,
  parameter int outputSize    = 24,
  parameter int PIPE_LAT      = 10,
  parameter int CNT_W         = 16
) (
  input  logic                                                   clk,
  input  logic                                                   nrst,
  input  logic                                                   start,
  input  logic [CNT_W-1:0]                                       num_vectors,
  input  logic                                                   w_valid,
  output logic                                                   w_ready,
  input  logic [numOutChannel*dataSize-1:0]                      w_data,
  input  logic                                                   act_valid,
  output logic                                                   act_ready,
  input  logic [kernelWidth*kernelWidth*dataSize-1:0]            act_data,
  output logic [kernelWidth*kernelWidth*dataSize-1:0]            array_act,
  output logic [kernelWidth*kernelWidth*numOutChannel*dataSize-1:0] array_weight,
  input  logic [numOutChannel*outputSize-1:0]                    array_result,
  output logic                                                   res_valid,
  output logic [numOutChannel*outputSize-1:0]                    res_data,
  output logic                                                   busy,
  output logic                                                   done
);

  localparam int nPEy   = kernelWidth * kernelWidth;
  localparam int nPEx   = numOutChannel;
  localparam int ROW_W  = nPEx * dataSize;
  localparam int WCNT_W = (nPEy > 1) ? $clog2(nPEy) : 1;
  localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(nPEy - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               n_total_q, n_total_d;
  logic [CNT_W-1:0]               a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]               r_cnt_q, r_cnt_d;
  logic [WCNT_W-1:0]              w_cnt_q, w_cnt_d;
  logic [nPEy*ROW_W-1:0]          bank_q, bank_d;
  logic [nPEy*dataSize-1:0]       act_q, act_d;
  logic [PIPE_LAT-1:0]            vld_q, vld_d;
  logic [nPEx*outputSize-1:0]     res_q, res_d;
  logic                           res_valid_q, res_valid_d;

  logic w_hs, a_hs;

  assign w_ready   = (state_q == S_LOAD_W);
  assign act_ready = (state_q == S_STREAM) && (a_cnt_q < n_total_q);
  assign w_hs      = w_valid && w_ready;
  assign a_hs      = act_valid && act_ready;

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign array_weight = bank_q;
  assign array_act    = act_q;
  assign res_data     = res_q;
  assign res_valid    = res_valid_q;

  always_comb begin
    state_d     = state_q;
    n_total_d   = n_total_q;
    a_cnt_d     = a_cnt_q;
    r_cnt_d     = r_cnt_q;
    w_cnt_d     = w_cnt_q;
    bank_d      = bank_q;
    act_d       = '0;
    res_d       = res_q;
    res_valid_d = 1'b0;
    vld_d       = vld_q;

    // Valid pipe mirrors the array latency; only a handshake injects a 1,
    // so bubbles travel through as zeros and never produce a strobe.
    if (state_q != S_IDLE) begin
      vld_d    = vld_q << 1;
      vld_d[0] = a_hs;
    end

    if (vld_q[PIPE_LAT-1]) begin
      res_d       = array_result;
      res_valid_d = 1'b1;
      r_cnt_d     = r_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_total_d = num_vectors;
          a_cnt_d   = '0;
          r_cnt_d   = '0;
          w_cnt_d   = '0;
          state_d   = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_hs) begin
          for (int unsigned r = 0; r < nPEy; r++) begin
            if (w_cnt_q == WCNT_W'(r)) bank_d[r*ROW_W +: ROW_W] = w_data;
          end
          w_cnt_d = w_cnt_q + 1'b1;
          if (w_cnt_q == W_LAST) begin
            state_d = (n_total_q == '0) ? S_DONE : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (a_hs) begin
          act_d   = act_data;
          a_cnt_d = a_cnt_q + 1'b1;
          if (a_cnt_q == n_total_q - 1'b1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // r_cnt and vld are both pre-edge values: the final strobe has been
        // issued and nothing is left in flight.
        if ((vld_q == '0) && (r_cnt_q == n_total_q)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      n_total_q   <= '0;
      a_cnt_q     <= '0;
      r_cnt_q     <= '0;
      w_cnt_q     <= '0;
      bank_q      <= '0;
      act_q       <= '0;
      vld_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_total_q   <= n_total_d;
      a_cnt_q     <= a_cnt_d;
      r_cnt_q     <= r_cnt_d;
      w_cnt_q     <= w_cnt_d;
      bank_q      <= bank_d;
      act_q       <= act_d;
      vld_q       <= vld_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// tb_tpu_seq_ctrl: randomized bench for tpu_seq_ctrl with a behavioural
// array model (latency PIPE_LAT) and a job-level reference scoreboard.
module tb_tpu_seq_ctrl;

  localparam int DS  = 8;
  localparam int KW  = 3;
  localparam int NOC = 3;
  localparam int OS  = 24;
  localparam int PL  = 10;
  localparam int CW  = 16;
  localparam int NY  = KW * KW;
  localparam int NX  = NOC;
  localparam int AW  = NY * DS;
  localparam int WW  = NX * DS;
  localparam int BW  = NY * NX * DS;
  localparam int RW  = NX * OS;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          w_valid;
  logic          w_ready;
  logic [WW-1:0] w_data;
  logic          act_valid;
  logic          act_ready;
  logic [AW-1:0] act_data;
  logic [AW-1:0] array_act;
  logic [BW-1:0] array_weight;
  logic [RW-1:0] array_result;
  logic          res_valid;
  logic [RW-1:0] res_data;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  tpu_seq_ctrl #(
    .dataSize(DS), .kernelWidth(KW), .numOutChannel(NOC),
    .outputSize(OS), .PIPE_LAT(PL), .CNT_W(CW)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .num_vectors(num_vectors),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .array_act(array_act), .array_weight(array_weight),
    .array_result(array_result), .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- array model: dot products, PL-1 register stages ----------
  function automatic logic [RW-1:0] array_mac(input logic [AW-1:0] a, input logic [BW-1:0] w);
    logic [RW-1:0] res;
    int unsigned   s;
    res = '0;
    for (int c = 0; c < NX; c++) begin
      s = 0;
      for (int r = 0; r < NY; r++)
        s += 32'(a[r*DS +: DS]) * 32'(w[(r*NX+c)*DS +: DS]);
      res[c*OS +: OS] = s[OS-1:0];
    end
    return res;
  endfunction

  logic [RW-1:0] apipe [PL-1];
  always @(posedge clk) begin
    apipe[0] <= array_mac(array_act, array_weight);
    for (int i = 1; i < PL-1; i++) apipe[i] <= apipe[i-1];
  end
  assign array_result = apipe[PL-2];

  // ---------------- reference data for the current job ----------------
  logic [DS-1:0] wt [NY][NX];
  logic [DS-1:0] av [64][NY];

  function automatic logic [WW-1:0] wrow(input int r);
    logic [WW-1:0] x;
    for (int c = 0; c < NX; c++) x[c*DS +: DS] = wt[r][c];
    return x;
  endfunction

  function automatic logic [BW-1:0] wt_packed();
    logic [BW-1:0] x;
    for (int r = 0; r < NY; r++)
      for (int c = 0; c < NX; c++) x[(r*NX+c)*DS +: DS] = wt[r][c];
    return x;
  endfunction

  function automatic logic [AW-1:0] act_packed(input int idx);
    logic [AW-1:0] x;
    for (int r = 0; r < NY; r++) x[r*DS +: DS] = av[idx][r];
    return x;
  endfunction

  function automatic logic [RW-1:0] ref_result(input int idx);
    logic [RW-1:0] res;
    int unsigned   s;
    res = '0;
    for (int c = 0; c < NX; c++) begin
      s = 0;
      for (int r = 0; r < NY; r++) s += 32'(av[idx][r]) * 32'(wt[r][c]);
      res[c*OS +: OS] = s[OS-1:0];
    end
    return res;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int            cyc = 0;
  int            done_exp = -1;
  bit            mon_en = 1'b0;
  bit            due;
  int            q_t [$];
  logic [RW-1:0] q_d [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      due = (q_t.size() > 0) && (q_t[0] + PL == cyc);
      check_eq("res_valid", res_valid, due);
      if (due) begin
        check_eq("res_data", res_data, q_d[0]);
        void'(q_t.pop_front());
        void'(q_d.pop_front());
      end
      check_eq("done", done, (cyc == done_exp));
    end
  end

  // ---------------- job driver ----------------
  task automatic run_job(input int n, input int vmode, input int rst_after, input bit disturb);
    int            rows, acc, k;
    bit            v, first;
    logic [AW-1:0] exp_act;

    check_eq("busy_idle", busy, 1'b0);
    start = 1'b1;
    num_vectors = CW'(n);
    @(negedge clk);
    start = 1'b0;
    num_vectors = CW'($urandom());
    check_eq("busy_load", busy, 1'b1);

    rows = 0;
    while (rows < NY) begin
      check_eq("w_ready_load", w_ready, 1'b1);
      check_eq("act_ready_load", act_ready, 1'b0);
      v = ($urandom_range(0, 3) != 0);
      w_valid  = v;
      w_data   = v ? wrow(rows) : WW'($urandom());
      act_valid = 1'($urandom_range(0, 1));
      act_data  = AW'({$urandom(), $urandom(), $urandom()});
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        num_vectors = CW'($urandom());
      end
      if (v && rows == NY-1 && n == 0) done_exp = cyc + 1;
      @(negedge clk);
      if (v) rows++;
    end
    w_valid = 1'b0;
    check_eq("array_weight_loaded", array_weight, wt_packed());

    exp_act = '0;
    acc = 0;
    k = 0;
    while (acc < n) begin
      if (acc == rst_after) begin
        nrst = 1'b0;
        act_valid = 1'b0;
        w_valid = 1'b0;
        start = 1'b0;
        q_t.delete();
        q_d.delete();
        done_exp = -1;
        @(negedge clk);
        nrst = 1'b1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_data", res_data, '0);
        check_eq("rst_w_ready", w_ready, 1'b0);
        check_eq("rst_act_ready", act_ready, 1'b0);
        check_eq("rst_array_act", array_act, '0);
        check_eq("rst_array_weight", array_weight, '0);
        repeat (PL + 3) @(negedge clk);
        return;
      end
      check_eq("act_ready_strm", act_ready, 1'b1);
      check_eq("w_ready_strm", w_ready, 1'b0);
      check_eq("array_act_strm", array_act, exp_act);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      k++;
      act_valid = v;
      act_data  = v ? act_packed(acc) : AW'({$urandom(), $urandom(), $urandom()});
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        num_vectors = CW'($urandom());
        w_valid = 1'b1;
        w_data = WW'($urandom());
      end
      if (v) begin
        q_t.push_back(cyc + 1);
        q_d.push_back(ref_result(acc));
        if (acc == n - 1) done_exp = cyc + PL + 2;
      end
      exp_act = v ? act_packed(acc) : '0;
      @(negedge clk);
      if (v) acc++;
    end

    first = 1'b1;
    while (cyc <= done_exp) begin
      check_eq("act_ready_drain", act_ready, 1'b0);
      check_eq("w_ready_drain", w_ready, 1'b0);
      check_eq("busy_drain", busy, 1'b1);
      check_eq(first ? "array_act_last" : "array_act_drain", array_act, first ? exp_act : '0);
      first = 1'b0;
      act_valid = 1'($urandom_range(0, 1));
      act_data  = AW'({$urandom(), $urandom(), $urandom()});
      w_valid   = 1'($urandom_range(0, 1));
      w_data    = WW'($urandom());
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        num_vectors = CW'($urandom());
      end
      @(negedge clk);
    end
    start = 1'b0;
    act_valid = 1'b0;
    w_valid = 1'b0;
    check_eq("busy_end", busy, 1'b0);
    check_eq("array_weight_stable", array_weight, wt_packed());
    @(negedge clk);
  endtask

  task automatic rand_data();
    for (int r = 0; r < NY; r++)
      for (int c = 0; c < NX; c++) wt[r][c] = DS'($urandom());
    for (int i = 0; i < 64; i++)
      for (int r = 0; r < NY; r++) av[i][r] = DS'($urandom());
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    w_valid = 1'b0;
    w_data = '0;
    act_valid = 1'b0;
    act_data = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_res_valid", res_valid, 1'b0);
    check_eq("reset_w_ready", w_ready, 1'b0);
    check_eq("reset_act_ready", act_ready, 1'b0);
    check_eq("reset_res_data", res_data, '0);
    check_eq("reset_array_weight", array_weight, '0);
    nrst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // single vector: weights all 1, activations all 2
    for (int r = 0; r < NY; r++) begin
      for (int c = 0; c < NX; c++) wt[r][c] = 8'd1;
      av[0][r] = 8'd2;
    end
    run_job(1, 0, -1, 1'b0);

    // four back-to-back vectors, weight (r,c) = c+1, vector i all i+1
    for (int r = 0; r < NY; r++) begin
      for (int c = 0; c < NX; c++) wt[r][c] = DS'(c + 1);
      for (int i = 0; i < 4; i++) av[i][r] = DS'(i + 1);
    end
    run_job(4, 0, -1, 1'b0);

    // alternating bubbles
    rand_data();
    run_job(3, 1, -1, 1'b0);

    // empty job
    rand_data();
    run_job(0, 0, -1, 1'b0);

    // reset mid-stream after two vectors, then a clean job
    rand_data();
    run_job(5, 0, 2, 1'b0);
    rand_data();
    run_job(5, 2, -1, 1'b0);

    // start / w_valid disturbances during the job
    rand_data();
    run_job(6, 2, -1, 1'b1);

    for (int j = 0; j < 6; j++) begin
      rand_data();
      run_job($urandom_range(1, 20), $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));
    end

    check_eq("scoreboard_empty", 32'(q_t.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
